mem_dbus_ctrl: RTL and testbench

Data-bus request controller between the MEM stage and the SRAM-like data bus. It turns the MEM stage's aligned load/store (address, lane-aligned write data, size) into a single `req`/`addr_ok`/`data_ok` transaction and returns the raw read word to the MEM byte selector. It raises `dmem_stall` to the hazard unit until the access completes, so each MEM-stage instruction issues exactly one bus access.

---
 rtl/mem_dbus_ctrl.sv | 118 +++++++++++
 tb/tb_mem_dbus_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_dbus_ctrl.sv
// MEM-stage data-bus controller: one req/addr_ok/data_ok transaction per
// load/store, with dmem_stall held until the access completes.
module mem_dbus_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_req_en,
  input  logic        mem_wr,
  input  logic [1:0]  mem_size,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        mem_except_valid,
  input  logic        pipe_stall,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic [31:0] mem_rdata,
  output logic        dmem_stall
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_HOLD
  } state_e;

  state_e      state_q, state_d;
  logic        wr_q, wr_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        start;
  logic        stall_raw;
  logic        pass;

  assign start = mem_req_en & ~mem_except_valid;

  always_comb begin
    state_d   = state_q;
    wr_d      = wr_q;
    size_d    = size_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    stall_raw = 1'b0;
    pass      = 1'b0;
    data_req  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        stall_raw = start;
        if (start) begin
          wr_d    = mem_wr;
          size_d  = mem_size;
          addr_d  = mem_addr;
          wdata_d = mem_wdata;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        // request stays up until accepted, even if an exception shows up
        data_req  = 1'b1;
        stall_raw = 1'b1;
        if (data_addr_ok) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        stall_raw = ~data_data_ok;
        if (data_data_ok) begin
          pass    = 1'b1;
          rdata_d = data_rdata;
          state_d = pipe_stall ? S_HOLD : S_IDLE;
        end
      end
      S_HOLD: begin
        // access done, instruction still parked in MEM: never reissue
        if (!pipe_stall) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      wr_q    <= 1'b0;
      size_q  <= 2'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign data_wr    = wr_q;
  assign data_size  = size_q;
  assign data_addr  = addr_q;
  assign data_wdata = wdata_q;
  assign mem_rdata  = pass ? data_rdata : rdata_q;
  assign dmem_stall = rst & stall_raw;

endmodule

// File: tb/tb_mem_dbus_ctrl.sv
// Bench for mem_dbus_ctrl: vector table replayed against a bus model,
// with a queue of expected requests/read data.
module tb_mem_dbus_ctrl;

  logic        clk;
  logic        rst;
  logic        mem_req_en;
  logic        mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_except_valid;
  logic        pipe_stall;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic [31:0] mem_rdata;
  logic        dmem_stall;

  mem_dbus_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .mem_req_en       (mem_req_en),
    .mem_wr           (mem_wr),
    .mem_size         (mem_size),
    .mem_addr         (mem_addr),
    .mem_wdata        (mem_wdata),
    .mem_except_valid (mem_except_valid),
    .pipe_stall       (pipe_stall),
    .data_req         (data_req),
    .data_wr          (data_wr),
    .data_size        (data_size),
    .data_addr        (data_addr),
    .data_wdata       (data_wdata),
    .data_addr_ok     (data_addr_ok),
    .data_data_ok     (data_data_ok),
    .data_rdata       (data_rdata),
    .mem_rdata        (mem_rdata),
    .dmem_stall       (dmem_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        exc;
    int          adly;
    int          ddly;
    int          hold;
  } vec_t;

  vec_t vecs [7];
  vec_t exp_q [$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run_txn(input vec_t v);
    int   reqc = 0;
    int   stc = 0;
    int   wcnt = 0;
    int   hc = 0;
    int   cyc = 0;
    bit   acc = 0;
    bit   dok = 0;
    bit   done = 0;
    vec_t e;
    exp_q.push_back(v);
    mem_req_en       = 1'b1;
    mem_wr           = v.wr;
    mem_size         = v.size;
    mem_addr         = v.addr;
    mem_wdata        = v.wdata;
    mem_except_valid = v.exc;
    while (!done && cyc < 64) begin
      data_addr_ok = 1'b0;
      data_data_ok = 1'b0;
      data_rdata   = $urandom;
      pipe_stall   = 1'b0;
      if (data_req && !acc) begin
        if (reqc == v.adly) begin
          data_addr_ok = 1'b1;
          acc = 1;
        end
      end else if (acc && !dok) begin
        if (wcnt == v.ddly) begin
          data_data_ok = 1'b1;
          data_rdata   = v.rdata;
          dok = 1;
        end else begin
          wcnt++;
        end
      end
      if (dok) pipe_stall = (hc < v.hold);
      @(negedge clk);
      if (data_req) begin
        reqc++;
        if (exp_q.size() == 0) begin
          chk("req_unexpected", 32'(data_req), 32'd0);
        end else begin
          chk("req_addr", data_addr, exp_q[0].addr);
          chk("req_wr", 32'(data_wr), 32'(exp_q[0].wr));
          chk("req_size", 32'(data_size), 32'(exp_q[0].size));
          chk("req_wdata", data_wdata, exp_q[0].wdata);
        end
      end
      if (dmem_stall) stc++;
      if (data_data_ok) begin
        e = exp_q.pop_front();
        chk("rdata_pass", mem_rdata, e.rdata);
        chk("stall_at_dok", 32'(dmem_stall), 32'd0);
      end else if (dok) begin
        chk("hold_rdata", mem_rdata, v.rdata);
        chk("hold_stall", 32'(dmem_stall), 32'd0);
      end
      if (dok) hc++;
      if (!dmem_stall && !pipe_stall) done = 1;
      cyc++;
      @(posedge clk);
      #1;
    end
    if (!done) chk("txn_timeout", 32'(cyc), 32'd0);
    chk("req_cycles", 32'(reqc), v.exc ? 32'd0 : 32'(v.adly + 1));
    chk("stall_cycles", 32'(stc),
        v.exc ? 32'd0 : 32'(2 + v.adly + v.ddly));
    exp_q.delete();
    pipe_stall   = 1'b0;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
  endtask

  initial begin
    vecs[0] = '{1'b0, 2'd2, 32'h8000_1004, 32'h0, 32'hDEAD_BEEF,
                1'b0, 0, 0, 0};
    vecs[1] = '{1'b1, 2'd0, 32'h8000_0003, 32'h5555_5555, 32'h1357_9BDF,
                1'b0, 3, 2, 0};
    vecs[2] = '{1'b0, 2'd2, 32'h0000_0100, 32'h0, 32'h1234_5678,
                1'b0, 0, 1, 3};
    vecs[3] = '{1'b0, 2'd2, 32'h8000_0001, 32'h0, 32'hFFFF_FFFF,
                1'b1, 0, 0, 0};
    vecs[4] = '{1'b0, 2'd2, 32'h0000_0010, 32'h0, 32'hA5A5_0010,
                1'b0, 0, 0, 0};
    vecs[5] = '{1'b0, 2'd2, 32'h0000_0014, 32'h0, 32'h5A5A_0014,
                1'b0, 1, 0, 0};
    vecs[6] = '{1'b1, 2'd1, 32'h0000_0022, 32'hBEEF_BEEF, 32'h0BAD_F00D,
                1'b0, 2, 0, 1};

    rst              = 1'b0;
    mem_req_en       = 1'b1;
    mem_wr           = 1'b1;
    mem_size         = 2'd2;
    mem_addr         = 32'h1234_5678;
    mem_wdata        = 32'hFFFF_FFFF;
    mem_except_valid = 1'b0;
    pipe_stall       = 1'b0;
    data_addr_ok     = 1'b0;
    data_data_ok     = 1'b0;
    data_rdata       = 32'h0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_req", 32'(data_req), 32'd0);
    chk("rst_wr", 32'(data_wr), 32'd0);
    chk("rst_size", 32'(data_size), 32'd0);
    chk("rst_addr", data_addr, 32'd0);
    chk("rst_wdata", data_wdata, 32'd0);
    chk("rst_rdata", mem_rdata, 32'd0);
    chk("rst_stall", 32'(dmem_stall), 32'd0);
    mem_req_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 7; i++) run_txn(vecs[i]);

    // reset while waiting for data_ok
    mem_req_en       = 1'b1;
    mem_wr           = 1'b0;
    mem_size         = 2'd2;
    mem_addr         = 32'h0000_0200;
    mem_except_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_req", 32'(data_req), 32'd1);
    data_addr_ok = 1'b1;
    @(posedge clk);
    #1;
    data_addr_ok = 1'b0;
    chk("mid_data_stall", 32'(dmem_stall), 32'd1);
    chk("mid_data_req", 32'(data_req), 32'd0);
    rst = 1'b0;
    #1;
    chk("arst_req", 32'(data_req), 32'd0);
    chk("arst_stall", 32'(dmem_stall), 32'd0);
    chk("arst_rdata", mem_rdata, 32'd0);
    chk("arst_addr", data_addr, 32'd0);
    mem_req_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_stall", 32'(dmem_stall), 32'd0);
    chk("post_rst_req", 32'(data_req), 32'd0);
    run_txn('{1'b0, 2'd2, 32'h0000_0300, 32'h0, 32'hCAFE_0300,
              1'b0, 1, 1, 0});

    mem_req_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("idle_req", 32'(data_req), 32'd0);
      chk("idle_stall", 32'(dmem_stall), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
